// File: rtl/trajeto_motorista.sv
// Ride-hailing route animation: the driver position walks one-hot towards the pickup, waits for
// boarding, then walks to the drop-off, flagging arrivals on the green LEDs.
module trajeto_motorista #(
  parameter int unsigned N_POS           = 9,
  parameter int unsigned PASSO_CICLOS    = 1,
  parameter int unsigned EMBARQUE_CICLOS = 4,
  parameter int unsigned LARG_VERDE      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inicia,
  input  logic                  cancelar,
  input  logic [N_POS-1:0]      pos_motorista,
  input  logic [N_POS-1:0]      inicio,
  input  logic [N_POS-1:0]      fim,
  output logic [N_POS-1:0]      fio,
  output logic [LARG_VERDE-1:0] acende_verde_2,
  output logic                  ocupado,
  output logic                  chegou_inicio,
  output logic                  concluido,
  output logic                  erro
);

  localparam logic [7:0] PassoMax = 8'(PASSO_CICLOS - 1);
  localparam logic [7:0] EmbMax   = 8'(EMBARQUE_CICLOS - 1);

  typedef enum logic [2:0] {OCIOSO, BUSCA, EMBARQUE, VIAGEM, FIM} estado_t;

  estado_t               r_estado, w_estado;
  logic [N_POS-1:0]      r_fio, w_fio;
  logic [N_POS-1:0]      r_alvo, w_alvo;
  logic [N_POS-1:0]      r_fim, w_fim;
  logic [LARG_VERDE-1:0] r_verde, w_verde;
  logic [7:0]            r_div, w_div;
  logic [7:0]            r_emb, w_emb;
  logic                  w_chegou, w_concl, w_erro;
  logic                  w_chegada, w_entradas_ok;

  assign w_chegada     = (r_fio == r_alvo);
  assign w_entradas_ok = $onehot(pos_motorista) && $onehot(inicio) && $onehot(fim);

  always_comb begin
    w_estado = r_estado;
    w_fio    = r_fio;
    w_alvo   = r_alvo;
    w_fim    = r_fim;
    w_verde  = r_verde;
    w_div    = r_div;
    w_emb    = r_emb;
    w_chegou = 1'b0;
    w_concl  = 1'b0;
    w_erro   = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (inicia) begin
          if (w_entradas_ok) begin
            w_fio    = pos_motorista;
            w_alvo   = inicio;
            w_fim    = fim;
            w_verde  = '0;
            w_div    = '0;
            w_estado = BUSCA;
          end else begin
            w_erro = 1'b1;
          end
        end
      end
      BUSCA, VIAGEM: begin
        // Cancel wins over arrival and suppresses the arrival pulse.
        if (cancelar) begin
          w_verde  = '0;
          w_estado = OCIOSO;
        end else if (w_chegada) begin
          w_verde = '1;
          if (r_estado == BUSCA) begin
            w_chegou = 1'b1;
            w_emb    = '0;
            w_estado = EMBARQUE;
          end else begin
            w_estado = FIM;
          end
        end else if (r_div == PassoMax) begin
          w_div = '0;
          w_fio = (r_fio > r_alvo) ? (r_fio >> 1) : (r_fio << 1);
        end else begin
          w_div = r_div + 8'd1;
        end
      end
      EMBARQUE: begin
        if (cancelar) begin
          w_verde  = '0;
          w_estado = OCIOSO;
        end else if (r_emb == EmbMax) begin
          w_verde  = '0;
          w_alvo   = r_fim;
          w_div    = '0;
          w_estado = VIAGEM;
        end else begin
          w_emb = r_emb + 8'd1;
        end
      end
      FIM: begin
        if (cancelar) begin
          w_verde = '0;
        end else begin
          w_concl = 1'b1;
        end
        w_estado = OCIOSO;
      end
      default: w_estado = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado <= OCIOSO;
      r_fio    <= {{(N_POS-1){1'b0}}, 1'b1};
      r_alvo   <= '0;
      r_fim    <= '0;
      r_verde  <= '0;
      r_div    <= '0;
      r_emb    <= '0;
    end else begin
      r_estado <= w_estado;
      r_fio    <= w_fio;
      r_alvo   <= w_alvo;
      r_fim    <= w_fim;
      r_verde  <= w_verde;
      r_div    <= w_div;
      r_emb    <= w_emb;
    end
  end

  // Pulses and ocupado are forced low while reset is held, even before the first reset edge.
  assign fio            = r_fio;
  assign acende_verde_2 = r_verde;
  assign ocupado        = !reset && (r_estado != OCIOSO);
  assign chegou_inicio  = !reset && w_chegou;
  assign concluido      = !reset && w_concl;
  assign erro           = !reset && w_erro;

endmodule

// File: tb/tb_trajeto_motorista.sv
// Bench for trajeto_motorista: two instances (1 and 3 cycles per step) share stimulus and are
// checked every cycle against a ride-timeline model, plus literal spot checks.
module tb_trajeto_motorista;

  localparam int PER0 = 1;
  localparam int PER1 = 3;
  localparam int EMB  = 4;

  logic       clk = 1'b0;
  logic       reset, inicia, cancelar;
  logic [8:0] pos_motorista, inicio, fim;
  logic [8:0] fio_a, fio_b;
  logic [7:0] vd_a, vd_b;
  logic       ocup_a, ocup_b, ch_a, ch_b, co_a, co_b, er_a, er_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model state per instance
  bit busy [2];
  int m_idx[2];
  bit m_vd [2];
  int rp[2], ri[2], rf[2], rt[2];

  always #5 clk = ~clk;

  trajeto_motorista #(
    .N_POS(9), .PASSO_CICLOS(PER0), .EMBARQUE_CICLOS(EMB), .LARG_VERDE(8)
  ) u_dut_a (
    .clk(clk), .reset(reset), .inicia(inicia), .cancelar(cancelar),
    .pos_motorista(pos_motorista), .inicio(inicio), .fim(fim),
    .fio(fio_a), .acende_verde_2(vd_a), .ocupado(ocup_a),
    .chegou_inicio(ch_a), .concluido(co_a), .erro(er_a)
  );

  trajeto_motorista #(
    .N_POS(9), .PASSO_CICLOS(PER1), .EMBARQUE_CICLOS(EMB), .LARG_VERDE(8)
  ) u_dut_b (
    .clk(clk), .reset(reset), .inicia(inicia), .cancelar(cancelar),
    .pos_motorista(pos_motorista), .inicio(inicio), .fim(fim),
    .fio(fio_b), .acende_verde_2(vd_b), .ocupado(ocup_b),
    .chegou_inicio(ch_b), .concluido(co_b), .erro(er_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [8:0] v);
    for (int b = 0; b < 9; b++) if (v[b]) return b;
    return 0;
  endfunction

  // Where the ride stands t cycles after BUSCA entry.
  function automatic void ride_at(input int pp, input int ii, input int ff, input int per,
                                  input int t, output int idx, output bit vd, output bit ch,
                                  output bit co, output bit last);
    int d1, d2, l1, l2, s1, s2;
    d1 = (pp > ii) ? pp - ii : ii - pp;
    d2 = (ii > ff) ? ii - ff : ff - ii;
    s1 = (ii > pp) ? 1 : -1;
    s2 = (ff > ii) ? 1 : -1;
    l1 = d1 * per + 1;
    l2 = d2 * per + 1;
    ch = 1'b0; co = 1'b0; last = 1'b0;
    if (t < l1) begin
      idx = pp + s1 * (t / per); vd = 1'b0; ch = (t == l1 - 1);
    end else if (t < l1 + EMB) begin
      idx = ii; vd = 1'b1;
    end else if (t < l1 + EMB + l2) begin
      idx = ii + s2 * ((t - l1 - EMB) / per); vd = 1'b0;
    end else begin
      idx = ff; vd = 1'b1; co = 1'b1; last = 1'b1;
    end
  endfunction

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      logic [8:0] a_fio, e_fio;
      logic [7:0] a_vd;
      logic       a_oc, a_ch, a_co, a_er;
      int         e_idx;
      bit         e_vd, e_ch, e_co, e_last;
      string      s;
      a_fio = (k == 0) ? fio_a : fio_b;
      a_vd  = (k == 0) ? vd_a : vd_b;
      a_oc  = (k == 0) ? ocup_a : ocup_b;
      a_ch  = (k == 0) ? ch_a : ch_b;
      a_co  = (k == 0) ? co_a : co_b;
      a_er  = (k == 0) ? er_a : er_b;
      s = (k == 0) ? "p1" : "p3";
      if (reset) begin
        chk({s, " ocupado@reset"}, 32'(a_oc), 32'd0);
        chk({s, " pulses@reset"}, 32'({a_ch, a_co, a_er}), 32'd0);
        busy[k] = 1'b0; m_idx[k] = 0; m_vd[k] = 1'b0;
      end else if (!busy[k]) begin
        bit ok;
        ok = $onehot(pos_motorista) && $onehot(inicio) && $onehot(fim);
        e_fio = 9'd1 << m_idx[k];
        chk({s, " idle fio"}, 32'(a_fio), 32'(e_fio));
        chk({s, " idle ledg"}, 32'(a_vd), m_vd[k] ? 32'hFF : 32'h0);
        chk({s, " idle ocupado"}, 32'(a_oc), 32'd0);
        chk({s, " idle chegou/concl"}, 32'({a_ch, a_co}), 32'd0);
        chk({s, " idle erro"}, 32'(a_er), 32'(inicia && !ok));
        if (inicia && ok) begin
          busy[k] = 1'b1; rt[k] = 0;
          rp[k] = oh_idx(pos_motorista); ri[k] = oh_idx(inicio); rf[k] = oh_idx(fim);
        end
      end else begin
        ride_at(rp[k], ri[k], rf[k], (k == 0) ? PER0 : PER1, rt[k], e_idx, e_vd, e_ch, e_co,
                e_last);
        if (cancelar) begin e_ch = 1'b0; e_co = 1'b0; end
        e_fio = 9'd1 << e_idx;
        chk({s, " ride fio"}, 32'(a_fio), 32'(e_fio));
        chk({s, " ride ledg"}, 32'(a_vd), e_vd ? 32'hFF : 32'h0);
        chk({s, " ride ocupado"}, 32'(a_oc), 32'd1);
        chk({s, " chegou_inicio"}, 32'(a_ch), 32'(e_ch));
        chk({s, " concluido"}, 32'(a_co), 32'(e_co));
        chk({s, " ride erro"}, 32'(a_er), 32'd0);
        if (cancelar) begin
          busy[k] = 1'b0; m_idx[k] = e_idx; m_vd[k] = 1'b0;
        end else if (e_last) begin
          busy[k] = 1'b0; m_idx[k] = rf[k]; m_vd[k] = 1'b1;
        end else begin
          rt[k]++;
        end
      end
    end
  endtask

  // One cycle: compare on the falling edge, return 1 time unit after the next rising edge.
  task automatic steps(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      compare_all();
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic start_ride(input logic [8:0] p, input logic [8:0] i, input logic [8:0] f);
    pos_motorista = p; inicio = i; fim = f; inicia = 1'b1;
    steps(1);
    inicia = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; inicia = 1'b0; cancelar = 1'b0;
    pos_motorista = 9'd1; inicio = 9'd1; fim = 9'd1;
    steps(2);
    reset = 1'b0;
    steps(2);

    // Long ride, 5 right shifts then 3 right shifts
    start_ride(9'b100000000, 9'b000001000, 9'b000000001);
    chk("t1 fio start", 32'(fio_a), 32'h100);
    chk("t1 ocupado", 32'(ocup_a), 32'd1);
    steps(5);
    chk("t1 fio pickup", 32'(fio_a), 32'h008);
    chk("t1 chegou_inicio", 32'(ch_a), 32'd1);
    chk("t1 p3 fio mid", 32'(fio_b), 32'h080);
    steps(1);
    chk("t1 ledg boarding", 32'(vd_a), 32'hFF);
    steps(8);
    chk("t1 concluido", 32'(co_a), 32'd1);
    chk("t1 fio dropoff", 32'(fio_a), 32'h001);
    chk("t1 ledg fim", 32'(vd_a), 32'hFF);
    steps(1);
    chk("t1 idle ocupado", 32'(ocup_a), 32'd0);
    chk("t1 ledg held", 32'(vd_a), 32'hFF);
    steps(18);

    // Three cycles per step: arrival 6 cycles after BUSCA entry
    start_ride(9'b000000001, 9'b000000100, 9'b000000100);
    chk("t2 p3 fio t0", 32'(fio_b), 32'h001);
    steps(2);
    chk("t2 p3 fio t2", 32'(fio_b), 32'h001);
    steps(1);
    chk("t2 p3 fio t3", 32'(fio_b), 32'h002);
    steps(3);
    chk("t2 p3 fio t6", 32'(fio_b), 32'h004);
    chk("t2 p3 chegou", 32'(ch_b), 32'd1);
    steps(10);

    // Two bits set in inicio
    inicio = 9'b000000110; pos_motorista = 9'b000000001; fim = 9'b000000001; inicia = 1'b1;
    #1;
    chk("t3 erro", 32'(er_a), 32'd1);
    chk("t3 ocupado", 32'(ocup_a), 32'd0);
    steps(1);
    inicia = 1'b0;
    #1;
    chk("t3 fio kept", 32'(fio_a), 32'h004);
    chk("t3 ocupado after", 32'(ocup_a), 32'd0);
    chk("t3 ledg kept", 32'(vd_a), 32'hFF);
    steps(2);

    // Zero-distance ride
    start_ride(9'b000010000, 9'b000010000, 9'b000010000);
    chk("t4 chegou p1", 32'(ch_a), 32'd1);
    chk("t4 chegou p3", 32'(ch_b), 32'd1);
    steps(6);
    chk("t4 concluido", 32'(co_a), 32'd1);
    chk("t4 fio", 32'(fio_a), 32'h010);
    steps(2);

    // Cancel in the VIAGEM arrival cycle
    start_ride(9'b000000010, 9'b000000010, 9'b000000100);
    steps(6);
    cancelar = 1'b1;
    #1;
    chk("t5 fio at arrival", 32'(fio_a), 32'h004);
    chk("t5 ocupado", 32'(ocup_a), 32'd1);
    steps(1);
    cancelar = 1'b0;
    #1;
    chk("t5 ocupado after", 32'(ocup_a), 32'd0);
    chk("t5 ledg cleared", 32'(vd_a), 32'h00);
    chk("t5 fio held", 32'(fio_a), 32'h004);
    chk("t5 p3 fio held", 32'(fio_b), 32'h002);
    steps(3);

    // inicia during VIAGEM is ignored
    start_ride(9'b000000001, 9'b000000100, 9'b000100000);
    steps(8);
    pos_motorista = 9'b100000000; inicio = 9'b100000000; fim = 9'b100000000; inicia = 1'b1;
    steps(1);
    inicia = 1'b0;
    steps(2);
    chk("t6 concluido", 32'(co_a), 32'd1);
    chk("t6 fio dropoff", 32'(fio_a), 32'h020);
    steps(12);

    // Reset mid-BUSCA
    start_ride(9'b100000000, 9'b000000001, 9'b000010000);
    steps(2);
    reset = 1'b1;
    steps(1);
    reset = 1'b0;
    #1;
    chk("t7 fio reset", 32'(fio_a), 32'h001);
    chk("t7 ledg reset", 32'(vd_a), 32'h00);
    chk("t7 ocupado reset", 32'(ocup_a), 32'd0);
    chk("t7 p3 fio reset", 32'(fio_b), 32'h001);
    steps(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trajeto_motorista.md
TRAJETO_MOTORISTA -- requirements
Module: trajeto_motorista

Interface
REQ-001 The block SHALL have parameter N_POS, default 9, giving the number of one-hot route positions (LEDR count).
REQ-002 The block SHALL have parameter PASSO_CICLOS, default 1, giving clock cycles per one-position step (legal range 1..255).
REQ-003 The block SHALL have parameter EMBARQUE_CICLOS, default 4, giving the boarding dwell in cycles (legal range 1..255).
REQ-004 The block SHALL have parameter LARG_VERDE, default 8, giving the LEDG bus width.
REQ-005 clk  in  1  the single clock; all logic SHALL update on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 inicia  in  1  one-cycle request to start a ride.
REQ-008 cancelar  in  1  abort the current ride.
REQ-009 pos_motorista  in  N_POS  one-hot driver start position.
REQ-010 inicio  in  N_POS  one-hot pickup position.
REQ-011 fim  in  N_POS  one-hot drop-off position.
REQ-012 fio  out  N_POS  one-hot current driver position (LEDR).
REQ-013 acende_verde_2  out  LARG_VERDE  arrival indication (LEDG).
REQ-014 ocupado  out  1  high while a ride is in progress.
REQ-015 chegou_inicio  out  1  one-cycle pulse on reaching the pickup position.
REQ-016 concluido  out  1  one-cycle pulse on reaching the drop-off position.
REQ-017 erro  out  1  one-cycle pulse when a request is rejected.

Function
REQ-018 FSM states SHALL be OCIOSO, BUSCA, EMBARQUE, VIAGEM, FIM.
REQ-019 In OCIOSO with inicia=1, all three position inputs SHALL be checked for exactly one bit set.
REQ-020 If all three inputs are valid, the block SHALL latch fio=pos_motorista, alvo=inicio, fim_reg=fim, clear acende_verde_2 and the divider, and enter BUSCA on the next cycle.
REQ-021 If any input is invalid, erro SHALL pulse for 1 cycle and the state, fio and acende_verde_2 SHALL stay unchanged.
REQ-022 inicia SHALL be ignored in every state other than OCIOSO.
REQ-023 In BUSCA and VIAGEM, arrival (fio==target) SHALL have priority and SHALL be checked every cycle; no shift occurs in an arrival cycle.
REQ-024 Otherwise the divider SHALL increment each cycle; when divider==PASSO_CICLOS-1, fio SHALL shift by one position and the divider SHALL clear.
REQ-025 The shift SHALL be right (>>1) when fio>target (unsigned) and left (<<1) when fio<target.
REQ-026 fio SHALL stay one-hot at all times; an unsigned compare of one-hot vectors is sufficient.
REQ-027 For distance d, the arrival cycle SHALL occur d*PASSO_CICLOS cycles after state entry; the state changes on the following edge.
REQ-028 d=0 SHALL produce an arrival in the first cycle of the state.
REQ-029 On BUSCA arrival, chegou_inicio SHALL pulse, acende_verde_2 SHALL become all ones, and the state SHALL go to EMBARQUE.
REQ-030 EMBARQUE SHALL last exactly EMBARQUE_CICLOS cycles.
REQ-031 On leaving EMBARQUE, acende_verde_2 SHALL be cleared, target SHALL be set to fim_reg, the divider SHALL clear, and the state SHALL go to VIAGEM.
REQ-032 On VIAGEM arrival, the state SHALL go to FIM and acende_verde_2 SHALL become all ones.
REQ-033 FIM SHALL last 1 cycle, with concluido=1 during it, and then return to OCIOSO.
REQ-034 acende_verde_2 SHALL stay all ones until the next accepted inicia.
REQ-035 ocupado SHALL be 1 in BUSCA, EMBARQUE, VIAGEM and FIM, and 0 in OCIOSO.
REQ-036 cancelar=1 in any busy state SHALL return the FSM to OCIOSO next cycle with fio held and acende_verde_2 cleared.
REQ-037 cancelar SHALL take priority over any arrival in the same cycle; no pulses are emitted in that case.
REQ-038 chegou_inicio, concluido and erro SHALL never be high in the same cycle.

Reset
REQ-039 While reset=1, the state SHALL be OCIOSO, fio={{N_POS-1{0}},1}, acende_verde_2=0, all pulses and ocupado SHALL be 0, and the divider and EMBARQUE counter SHALL be 0.
REQ-040 reset SHALL override all other inputs, including mid-ride and during cancelar.

Verification
REQ-041 N=9, P=1, pos=9'b100000000, inicio=9'b000001000, fim=9'b000000001 -> 5 right shifts; chegou_inicio pulses; LEDG=FF for 4 cycles; 3 right shifts; concluido pulses; LEDG=FF held.
REQ-042 P=3, pos=9'b000000001, inicio=9'b000000100 -> fio changes every 3 cycles; arrival 6 cycles after BUSCA entry.
REQ-043 inicio=9'b000000110 (two bits set) -> erro pulses once; ocupado stays 0; fio unchanged.
REQ-044 pos==inicio==fim -> chegou_inicio in the first BUSCA cycle, EMBARQUE dwell, then concluido; fio never changes.
REQ-045 cancelar asserted in VIAGEM in the same cycle as arrival -> OCIOSO next cycle; no concluido; LEDG=0.
REQ-046 reset asserted mid-BUSCA, and inicia pulsed during VIAGEM -> reset gives REQ-039 values next cycle; inicia during VIAGEM has no effect.
